// File: rtl/fica_pkg.sv
// fica_pkg: shared widths, FSM states and saturation helper for the FastICA expectation step.
package fica_pkg;
    localparam int DW = 26;
    localparam int NSAMP_LOG2 = 10;
    localparam int ACCW = DW + NSAMP_LOG2;
    localparam int LANES = 16;
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_e;
    function automatic logic [DW-1:0] sat_dw(input logic signed [DW+2:0] x);
        return x > $signed({4'b0000, {(DW-1){1'b1}}}) ? {1'b0, {(DW-1){1'b1}}} :
               x < $signed({4'b1111, {(DW-1){1'b0}}}) ? {1'b1, {(DW-1){1'b0}}} : x[DW-1:0];
    endfunction
endpackage

// File: rtl/mul4_acc_ctrl_if.sv
// mul4_acc_ctrl_if: control, sample-RAM and MUL4 lane bus of the expectation sequencer.
interface mul4_acc_ctrl_if #(parameter int DW = fica_pkg::DW, parameter int NSAMP_LOG2 = fica_pkg::NSAMP_LOG2);
    logic                    start;
    logic                    busy;
    logic                    done;
    logic                    samp_rd;
    logic [NSAMP_LOG2-1:0]   samp_addr;
    logic                    en_mul;
    logic [16*DW-1:0]        mul_o;
    logic [16*DW-1:0]        w_in;
    logic [16*DW-1:0]        mean_o;
    modport master (output start, mul_o, w_in, input busy, done, samp_rd, samp_addr, en_mul, mean_o);
    modport slave  (input start, mul_o, w_in, output busy, done, samp_rd, samp_addr, en_mul, mean_o);
endinterface

// File: rtl/fica_acc_lane.sv
// fica_acc_lane: one accumulator lane with mean shift; FICA_W_UPDATE_EN adds mean-3w with saturation.
module fica_acc_lane #(
    parameter int DW = fica_pkg::DW,
    parameter int NSAMP_LOG2 = fica_pkg::NSAMP_LOG2,
    parameter int ACCW = DW + NSAMP_LOG2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          acc_en_i,
    input  logic          ld_i,
    input  logic [DW-1:0] mul_i,
`ifdef FICA_W_UPDATE_EN
    input  logic [DW-1:0] w_i,
`endif
    output logic [DW-1:0] mean_o
);
    logic signed [ACCW-1:0] acc_q, acc_d, sh;
    logic [DW-1:0] mean, res, mean_q;
    always_comb begin
        acc_d = clr_i ? '0 : acc_en_i ? acc_q + {{NSAMP_LOG2{mul_i[DW-1]}}, mul_i} : acc_q;
        sh = acc_d >>> NSAMP_LOG2;
        mean = sh[DW-1:0];
    end
`ifdef FICA_W_UPDATE_EN
    logic signed [DW+1:0] w3;
    logic signed [DW+2:0] diff;
    always_comb begin
        w3 = ({{2{w_i[DW-1]}}, w_i} << 1) + {{2{w_i[DW-1]}}, w_i};
        diff = {{3{mean[DW-1]}}, mean} - {w3[DW+1], w3};
        res = fica_pkg::sat_dw(diff);
    end
`else
    assign res = mean;
`endif
    // The mean is captured from the final accumulator value on the edge entering DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            mean_q <= '0;
        end else begin
            acc_q <= acc_d;
            mean_q <= ld_i ? res : mean_q;
        end
    end
    assign mean_o = mean_q;
endmodule

// File: rtl/mul4_acc_ctrl.sv
// mul4_acc_ctrl: sequences one FastICA expectation pass over N samples into 16 lane means (FICA_W_UPDATE_EN optional).
module mul4_acc_ctrl #(
    parameter int DW = fica_pkg::DW,
    parameter int NSAMP_LOG2 = fica_pkg::NSAMP_LOG2,
    parameter int ACCW = DW + NSAMP_LOG2
) (
    input logic clk_ctrl,
    input logic rst_ctrl,
    mul4_acc_ctrl_if.slave bus
);
    fica_pkg::state_e state_q, state_d;
    logic [NSAMP_LOG2-1:0] addr_q, addr_d;
    logic drn_q, drn_d, rd_d1_q, rd_d2_q, samp_rd, ld;
    logic [16*DW-1:0] mean_w;
    always_ff @(posedge clk_ctrl) begin
        if (rst_ctrl) begin
            state_q <= fica_pkg::IDLE;
            addr_q <= '0;
            drn_q <= 1'b0;
            rd_d1_q <= 1'b0;
            rd_d2_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            drn_q <= drn_d;
            rd_d1_q <= samp_rd;
            rd_d2_q <= rd_d1_q;
        end
    end
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            fica_pkg::IDLE:  state_d = bus.start ? fica_pkg::FETCH : fica_pkg::IDLE;
            fica_pkg::FETCH: state_d = &addr_q ? fica_pkg::DRAIN : fica_pkg::FETCH;
            fica_pkg::DRAIN: state_d = drn_q ? fica_pkg::DONE : fica_pkg::DRAIN;
            default:         state_d = fica_pkg::IDLE;
        endcase
        addr_d = state_q == fica_pkg::FETCH ? addr_q + 1'b1 : '0;
        drn_d = state_q == fica_pkg::DRAIN ? ~drn_q : 1'b0;
    end
    always_comb begin
        samp_rd = state_q == fica_pkg::FETCH;
        ld = state_q == fica_pkg::DRAIN && drn_q;
        bus.busy = state_q == fica_pkg::FETCH || state_q == fica_pkg::DRAIN;
        bus.done = state_q == fica_pkg::DONE;
    end
    assign bus.samp_rd = samp_rd;
    assign bus.samp_addr = addr_q;
    assign bus.en_mul = rd_d1_q;
    assign bus.mean_o = mean_w;
    for (genvar j = 0; j < fica_pkg::LANES; j++) begin : g_lane
        fica_acc_lane #(.DW(DW), .NSAMP_LOG2(NSAMP_LOG2), .ACCW(ACCW)) u_lane (
            .clk(clk_ctrl),
            .rst(rst_ctrl),
            .clr_i(state_q == fica_pkg::IDLE),
            .acc_en_i(rd_d2_q),
            .ld_i(ld),
            .mul_i(bus.mul_o[j*DW +: DW]),
`ifdef FICA_W_UPDATE_EN
            .w_i(bus.w_in[j*DW +: DW]),
`endif
            .mean_o(mean_w[j*DW +: DW])
        );
    end
endmodule

// File: tb/tb_mul4_acc_ctrl.sv
// tb_mul4_acc_ctrl: directed table-driven bench for mul4_acc_ctrl with N=4 (honours FICA_W_UPDATE_EN).
module tb_mul4_acc_ctrl;
    localparam int DW = 26;
    localparam int NL = 2;
    localparam int N = 4;
    localparam int W = 16 * DW;
    localparam int MAXV = 33554431;
    localparam int MINV = -33554432;
    typedef struct {
        int v [4];
        int o;
        int w;
        int e0;
        int eo;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    logic [W-1:0] prev;
    vec_t vecs [8];
    mul4_acc_ctrl_if #(.DW(DW), .NSAMP_LOG2(NL)) bus ();
    mul4_acc_ctrl #(.DW(DW), .NSAMP_LOG2(NL)) dut (.clk_ctrl(clk), .rst_ctrl(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [W-1:0] a, input logic [W-1:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask
    function automatic logic [W-1:0] lanes(input int l0, input int lo);
        logic [W-1:0] r;
        for (int j = 0; j < 16; j++) r[j*DW +: DW] = j == 0 ? l0[DW-1:0] : lo[DW-1:0];
        return r;
    endfunction
    function automatic int upd(input int m, input int w);
`ifdef FICA_W_UPDATE_EN
        longint d = longint'(m) - 3 * longint'(w);
        return d > MAXV ? MAXV : d < MINV ? MINV : int'(d);
`else
        return m + 0 * w;
`endif
    endfunction
    task automatic setv(input int i, input int a, input int b, input int c, input int d,
                        input int o, input int w, input int e0, input int eo);
        vecs[i].v[0] = a; vecs[i].v[1] = b; vecs[i].v[2] = c; vecs[i].v[3] = d;
        vecs[i].o = o; vecs[i].w = w; vecs[i].e0 = e0; vecs[i].eo = eo;
    endtask
    task automatic run_pass(input int i, input bit hold);
        logic [W-1:0] exp_m;
        exp_m = lanes(upd(vecs[i].e0, vecs[i].w), upd(vecs[i].eo, vecs[i].w));
        bus.start = 1'b1;
        bus.w_in = lanes(vecs[i].w, vecs[i].w);
        @(posedge clk); #1;
        bus.start = hold;
        for (int c = 1; c <= N + 3; c++) begin
            bus.mul_o = (c >= 3 && c <= N + 2) ? lanes(vecs[i].v[c-3], vecs[i].o) : lanes(12345, -777);
            @(negedge clk);
            chk($sformatf("v%0d c%0d busy", i, c), W'(bus.busy), W'(c <= N + 2));
            chk($sformatf("v%0d c%0d done", i, c), W'(bus.done), W'(c == N + 3));
            chk($sformatf("v%0d c%0d samp_rd", i, c), W'(bus.samp_rd), W'(c <= N));
            chk($sformatf("v%0d c%0d samp_addr", i, c), W'(bus.samp_addr), c <= N ? W'(c - 1) : W'(0));
            chk($sformatf("v%0d c%0d en_mul", i, c), W'(bus.en_mul), W'(c >= 2 && c <= N + 1));
            chk($sformatf("v%0d c%0d mean_o", i, c), bus.mean_o, c == N + 3 ? exp_m : prev);
            @(posedge clk); #1;
        end
        prev = exp_m;
    endtask
    task automatic chk_idle(input string nm);
        chk({nm, " busy"}, W'(bus.busy), W'(0));
        chk({nm, " done"}, W'(bus.done), W'(0));
        chk({nm, " samp_rd"}, W'(bus.samp_rd), W'(0));
        chk({nm, " samp_addr"}, W'(bus.samp_addr), W'(0));
        chk({nm, " en_mul"}, W'(bus.en_mul), W'(0));
        chk({nm, " mean_o"}, bus.mean_o, prev);
    endtask
    initial begin
        setv(0, 8192, 8192, 8192, 8192, 8192, 0, 8192, 8192);
        setv(1, 100, -300, 50, -2, 0, 0, -38, 0);
        setv(2, 1, 1, 1, 0, -1, 0, 0, -1);
        setv(3, -1, 0, 0, 0, 3, 0, -1, 3);
        setv(4, MAXV, MAXV, MAXV, MAXV, MINV, 0, MAXV, MINV);
        setv(5, 8192, 8192, 8192, 8192, 8192, MAXV, 8192, 8192);
        setv(6, 8192, 8192, 8192, 8192, 8192, 1000, 8192, 8192);
        setv(7, 8192, 8192, 8192, 8192, 8192, MINV, 8192, 8192);
        bus.start = 1'b0;
        bus.mul_o = lanes(12345, -777);
        bus.w_in = '0;
        prev = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle("reset");
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk_idle($sformatf("idle%0d", c));
        end
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            run_pass(i, 1'b0);
            @(negedge clk);
            chk_idle($sformatf("after v%0d", i));
            @(posedge clk); #1;
        end
        run_pass(0, 1'b1);
        run_pass(1, 1'b1);
        bus.start = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk_idle("after b2b");
        end
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        prev = '0;
        @(negedge clk);
        chk_idle("midpass reset");
        @(posedge clk); #1;
        run_pass(4, 1'b0);
        @(negedge clk);
        chk_idle("after reset pass");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
